// File: rtl/inst_queue.sv
`default_nettype none
// inst_queue: in-order {pc,inst} FIFO between fetch and decode.
// Revision 1.0. Flush clears the queue, and there is no bypass from fetch to decode.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_to_id_valid,
  input  logic [31:0]      if_to_id_pc,
  input  logic [31:0]      if_to_id_inst,
  output logic             i_id_ready,
  input  logic             flush,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_pc,
  output logic [31:0]      dec_inst,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  logic [63:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             w_push;
  logic             w_pop;
  logic [63:0]      w_head;

  // Ready is gated by rst_n so it reads 0 while reset is asserted, even between clock edges.
  assign i_id_ready = rst_n & (cnt_q != C_DEPTH) & ~flush;
  assign dec_valid  = (cnt_q != '0) & ~flush;
  assign w_push     = if_to_id_valid & i_id_ready;
  assign w_pop      = dec_valid & dec_ready;
  assign w_head     = mem_q[rptr_q];
  assign dec_pc     = dec_valid ? w_head[63:32] : 32'h0;
  assign dec_inst   = dec_valid ? w_head[31:0]  : 32'h0;
  assign count      = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + C_PTR_ONE;
      if (w_pop)  rptr_d = rptr_q + C_PTR_ONE;
      if (w_push && !w_pop)      cnt_d = cnt_q + C_CNT_ONE;
      else if (!w_push && w_pop) cnt_d = cnt_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately not reset; the occupancy count alone determines whether an entry is live.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= {if_to_id_pc, if_to_id_inst};
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// tb_inst_queue: directed self-checking bench for inst_queue (DEPTH=4).
// Revision 1.0.
module tb_inst_queue;

  logic        clk;
  logic        rst_n;
  logic        if_to_id_valid;
  logic [31:0] if_to_id_pc;
  logic [31:0] if_to_id_inst;
  logic        i_id_ready;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic [2:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  inst_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_to_id_valid (if_to_id_valid),
    .if_to_id_pc    (if_to_id_pc),
    .if_to_id_inst  (if_to_id_inst),
    .i_id_ready     (i_id_ready),
    .flush          (flush),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_inst       (dec_inst),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock edge, then check the occupancy bound away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("cnt_le_depth", {31'd0, (count <= 3'd4)}, 32'd1);
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_to_id_valid = v;
    if_to_id_pc    = pc;
    if_to_id_inst  = inst;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_ready", {31'd0, i_id_ready}, 32'd0);
    check("rst_dec_pc", dec_pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, i_id_ready}, 32'd1);

    // Fill the queue with no pops.
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 32'h1c000000 + 32'(4*i), 32'h00000013 + 32'(i << 8));
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_ready", {31'd0, i_id_ready}, 32'd0);
    check("fill_head_pc", dec_pc, 32'h1c000000);
    check("fill_dec_valid", {31'd0, dec_valid}, 32'd1);

    // Drain. On the first cycle, a push is offered while the queue is full, and the queue must refuse it.
    dec_ready = 1'b1;
    offer(1'b1, 32'h1c000010, 32'hdeadbeef);
    #1;
    check("full_pop_ready", {31'd0, i_id_ready}, 32'd0);
    check("drain_pc0", dec_pc, 32'h1c000000);
    check("drain_inst0", dec_inst, 32'h00000013);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("ready_after_pop", {31'd0, i_id_ready}, 32'd1);
    check("count_after_pop", {29'd0, count}, 32'd3);
    for (int i = 1; i < 4; i++) begin
      check("drain_pc", dec_pc, 32'h1c000000 + 32'(4*i));
      check("drain_inst", dec_inst, 32'h00000013 + 32'(i << 8));
      tick();
    end
    check("drain_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("drain_count", {29'd0, count}, 32'd0);
    check("drain_dec_pc_zero", dec_pc, 32'h0);

    // Push and pop in the same cycle.
    dec_ready = 1'b0;
    offer(1'b1, 32'h2000_0000, 32'hA0); tick();
    offer(1'b1, 32'h2000_0004, 32'hA1); tick();
    check("conc_count_pre", {29'd0, count}, 32'd2);
    dec_ready = 1'b1;
    offer(1'b1, 32'h2000_0008, 32'hA2);
    #1;
    check("conc_head", dec_pc, 32'h2000_0000);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    check("conc_count", {29'd0, count}, 32'd2);
    check("conc_head1", dec_pc, 32'h2000_0004);
    tick();
    check("conc_head2", dec_pc, 32'h2000_0008);
    tick();
    check("conc_empty", {29'd0, count}, 32'd0);

    // Flush with a push offered in the same cycle.
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 32'h3000_0000 + 32'(4*i), 32'hB0 + 32'(i));
      tick();
    end
    check("flush_pre_count", {29'd0, count}, 32'd3);
    flush = 1'b1;
    dec_ready = 1'b1;
    offer(1'b1, 32'hdead0000, 32'hdead0001);
    #1;
    check("flush_ready", {31'd0, i_id_ready}, 32'd0);
    check("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
    check("flush_dec_pc", dec_pc, 32'h0);
    tick();
    check("flush_hold_count", {29'd0, count}, 32'd0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_dec_valid2", {31'd0, dec_valid}, 32'd0);
    dec_ready = 1'b0;
    offer(1'b1, 32'h3100_0000, 32'hC0); tick();
    offer(1'b0, 32'h0, 32'h0);
    check("post_flush_head", dec_pc, 32'h3100_0000);
    check("post_flush_count", {29'd0, count}, 32'd1);
    dec_ready = 1'b1; tick(); dec_ready = 1'b0;

    // Wrap the pointers: start with one entry queued, then run six push/pop pairs.
    offer(1'b1, 32'h4000_0000, 32'h1000); tick();
    dec_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      offer(1'b1, 32'h4000_0000 + 32'(4*i), 32'h1000 + 32'(i));
      #1;
      check("wrap_inst", dec_inst, 32'h1000 + 32'(i - 1));
      tick();
      check("wrap_count", {29'd0, count}, 32'd1);
    end
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("wrap_last", dec_inst, 32'h1006);
    tick();
    dec_ready = 1'b0;
    check("wrap_empty", {29'd0, count}, 32'd0);

    // Assert reset in the middle of a cycle while the queue is occupied.
    offer(1'b1, 32'h5000_0000, 32'hD0); tick();
    offer(1'b1, 32'h5000_0004, 32'hD1); tick();
    offer(1'b0, 32'h0, 32'h0);
    check("rst_pre_count", {29'd0, count}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, dec_valid}, 32'd0);
    check("async_rst_count", {29'd0, count}, 32'd0);
    check("async_rst_ready", {31'd0, i_id_ready}, 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_ready", {31'd0, i_id_ready}, 32'd1);
    offer(1'b1, 32'h6000_0000, 32'hE0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    check("rel_head_valid", {31'd0, dec_valid}, 32'd1);
    check("rel_head_pc", dec_pc, 32'h6000_0000);
    check("rel_head_inst", dec_inst, 32'hE0);
    check("rel_count", {29'd0, count}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
